// File: rtl/cpm_pkg.sv
// -----------------------------------------------------------------------------
// cpm_pkg
// Shared definitions for the CPM drain serializer slice.
//   cpm_state_e : FSM state encoding (IDLE, DRAIN)
//   CPM_DW      : default word width
//   clog2_min1  : index-width helper that never returns 0
// Optional build macro used by this slice: CPM_DRAIN_B2B_EN (see cpm_drain_ser).
// -----------------------------------------------------------------------------
package cpm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } cpm_state_e;

    localparam int CPM_DW = 8;

    // A one-word bank would otherwise get a zero-width index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpm_drain_ser_if.sv
// -----------------------------------------------------------------------------
// cpm_drain_ser_if
// Load and output stream bundle of the CPM drain serializer.
//   LdVld/LdRdy/LdData      : parallel snapshot handshake (NUM*DW bits)
//   OutVld/OutRdy/OutData   : serialized word stream (DW bits)
//   OutIdx/OutLast          : index of the current word, last-word flag
//   Busy                    : a snapshot is held
// Modports: slave = serializer side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface cpm_drain_ser_if
    import cpm_pkg::*;
#(
    parameter int DW  = CPM_DW,
    parameter int NUM = 16
);
    localparam int IDXW = clog2_min1(NUM);

    logic                LdVld;
    logic                LdRdy;
    logic [NUM*DW-1:0]   LdData;
    logic                OutVld;
    logic                OutRdy;
    logic [DW-1:0]       OutData;
    logic [IDXW-1:0]     OutIdx;
    logic                OutLast;
    logic                Busy;

    modport slave (
        input  LdVld, LdData, OutRdy,
        output LdRdy, OutVld, OutData, OutIdx, OutLast, Busy
    );

    modport master (
        output LdVld, LdData, OutRdy,
        input  LdRdy, OutVld, OutData, OutIdx, OutLast, Busy
    );

endinterface

// File: rtl/cpm_drain_bank.sv
// -----------------------------------------------------------------------------
// cpm_drain_bank
// NUM x DW snapshot registers with a read mux.
//   Clk    : clock
//   Rst    : synchronous active-high reset (bank -> 0)
//   Clr    : synchronous flush (bank -> 0), same effect as Rst
//   LdEn   : capture all NUM words of LdData
//   LdData : packed snapshot, word i = LdData[i*DW +: DW]
//   RdIdx  : word select
//   RdData : bank[RdIdx]
// -----------------------------------------------------------------------------
module cpm_drain_bank
    import cpm_pkg::*;
#(
    parameter int DW   = CPM_DW,
    parameter int NUM  = 16,
    parameter int IDXW = clog2_min1(NUM)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Clr,
    input  logic              LdEn,
    input  logic [NUM*DW-1:0] LdData,
    input  logic [IDXW-1:0]   RdIdx,
    output logic [DW-1:0]     RdData
);

    logic [DW-1:0] bank_q [NUM];

    // NOTE: the bank is reset on purpose: a flushed snapshot must read back
    // as zero, so this array cannot be left to power-up values like a RAM.
    always_ff @(posedge Clk) begin
        if (Rst || Clr) begin
            for (int i = 0; i < NUM; i++) begin
                bank_q[i] <= '0;
            end
        end else if (LdEn) begin
            for (int i = 0; i < NUM; i++) begin
                bank_q[i] <= LdData[i*DW +: DW];
            end
        end
    end

    // The index never exceeds NUM-1, so the mux needs no range guard.
    assign RdData = bank_q[RdIdx];

endmodule

// File: rtl/cpm_drain_ser.sv
// -----------------------------------------------------------------------------
// cpm_drain_ser
// Takes a parallel snapshot of NUM words and serializes it, index order, onto
// a DW-wide valid/ready stream. Sits between the CPM register bank and the
// output/write-back path.
//   Clk   : clock
//   Rst   : synchronous active-high reset
//   Clear : synchronous abort, same effect as Rst
//   bus   : cpm_drain_ser_if.slave (load handshake, output stream, Busy)
// Build option:
//   CPM_DRAIN_B2B_EN defined -> in DRAIN, LdRdy = OutRdy & last index; a load
//   taken with the last beat restarts the drain with no IDLE gap.
//   Undefined (default)      -> LdRdy=0 throughout DRAIN, one IDLE cycle
//   between snapshots.
// -----------------------------------------------------------------------------
module cpm_drain_ser
    import cpm_pkg::*;
#(
    parameter int DW  = CPM_DW,
    parameter int NUM = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Clear,
    cpm_drain_ser_if.slave    bus
);

    localparam int              IDXW     = clog2_min1(NUM);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM - 1);

    cpm_state_e      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            ld_en;
    logic            is_last;
    logic [DW-1:0]   rd_data;

    cpm_drain_bank #(
        .DW   (DW),
        .NUM  (NUM),
        .IDXW (IDXW)
    ) u_bank (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clr    (Clear),
        .LdEn   (ld_en),
        .LdData (bus.LdData),
        .RdIdx  (idx_q),
        .RdData (rd_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign is_last = (idx_q == LAST_IDX);

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ld_en       = 1'b0;
        bus.LdRdy   = 1'b0;
        bus.OutVld  = 1'b0;
        bus.OutData = '0;
        bus.OutIdx  = '0;
        bus.OutLast = 1'b0;
        bus.Busy    = 1'b0;

        case (state_q)
            IDLE: begin
                bus.LdRdy = 1'b1;
                if (bus.LdVld) begin
                    ld_en   = 1'b1;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // Stream outputs come from state, index and bank registers
                // only, so they hold still under backpressure.
                bus.OutVld  = 1'b1;
                bus.OutData = rd_data;
                bus.OutIdx  = idx_q;
                bus.OutLast = is_last;
                bus.Busy    = 1'b1;
`ifdef CPM_DRAIN_B2B_EN
                // The one intended input-to-output path: a new snapshot may
                // land exactly when the last word leaves.
                bus.LdRdy = bus.OutRdy && is_last;
`endif
                if (bus.OutRdy) begin
                    if (is_last) begin
                        idx_d = '0;
`ifdef CPM_DRAIN_B2B_EN
                        if (bus.LdVld) begin
                            ld_en   = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpm_drain_ser.sv
// -----------------------------------------------------------------------------
// tb_cpm_drain_ser
// Directed bench for cpm_drain_ser (DW=8, NUM=16). Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
// Expectations follow the CPM_DRAIN_B2B_EN build setting where they differ.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpm_drain_ser;

    localparam int DW   = 8;
    localparam int NUM  = 16;
    localparam int IDXW = 4;

    logic Clk;
    logic Rst;
    logic Clear;

    int tests;
    int fails;

    cpm_drain_ser_if #(.DW(DW), .NUM(NUM)) bus ();

    cpm_drain_ser #(.DW(DW), .NUM(NUM)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Clear (Clear),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    function automatic logic [DW-1:0] wordf(input logic [DW-1:0] base,
                                            input logic [DW-1:0] step,
                                            input int i);
        return base + DW'(i) * step;
    endfunction

    function automatic logic [NUM*DW-1:0] mk_pat(input logic [DW-1:0] base,
                                                  input logic [DW-1:0] step);
        logic [NUM*DW-1:0] p;
        p = '0;
        for (int i = 0; i < NUM; i++) begin
            p[i*DW +: DW] = wordf(base, step, i);
        end
        return p;
    endfunction

    task automatic cyc();
        @(negedge Clk);
    endtask

    // Offer a snapshot for one cycle; caller is at a falling edge in IDLE.
    task automatic do_load(input logic [NUM*DW-1:0] d);
        bus.LdVld  = 1'b1;
        bus.LdData = d;
        cyc();
        bus.LdVld  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst        = 1'b1;
        Clear      = 1'b0;
        bus.LdVld  = 1'b0;
        bus.LdData = '0;
        bus.OutRdy = 1'b0;
        cyc();
        cyc();
        tests++;
        if ({bus.LdRdy, bus.OutVld, bus.OutData, bus.OutIdx, bus.OutLast, bus.Busy}
            !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs: got LdRdy=%b OutVld=%b OutData=%h OutIdx=%0d OutLast=%b Busy=%b, required 1 0 00 0 0 0",
                     bus.LdRdy, bus.OutVld, bus.OutData, bus.OutIdx, bus.OutLast, bus.Busy);
        end
        Rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic [NUM*DW-1:0] pat;
        logic              exp_rdy;
        pat        = mk_pat(8'd1, 8'd1);
        bus.OutRdy = 1'b1;
        tests++;
        if (bus.LdRdy !== 1'b1) begin
            fails++;
            $display("FAIL basic_ldrdy_idle: got %b required 1", bus.LdRdy);
        end
        do_load(pat);
        for (int i = 0; i < NUM; i++) begin
`ifdef CPM_DRAIN_B2B_EN
            exp_rdy = (i == NUM - 1);
`else
            exp_rdy = 1'b0;
`endif
            tests++;
            if ({bus.OutVld, bus.OutIdx, bus.OutLast, bus.OutData, bus.LdRdy, bus.Busy}
                !== {1'b1, IDXW'(i), (i == NUM - 1), DW'(i + 1), exp_rdy, 1'b1}) begin
                fails++;
                $display("FAIL basic_beat[%0d]: got vld=%b idx=%0d last=%b data=%h ldrdy=%b busy=%b, required 1 %0d %b %h %b 1",
                         i, bus.OutVld, bus.OutIdx, bus.OutLast, bus.OutData, bus.LdRdy, bus.Busy,
                         i, (i == NUM - 1), DW'(i + 1), exp_rdy);
            end
            cyc();
        end
        tests++;
        if ({bus.OutVld, bus.LdRdy, bus.Busy, bus.OutData} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL basic_return_idle: got vld=%b ldrdy=%b busy=%b data=%h, required 0 1 0 00",
                     bus.OutVld, bus.LdRdy, bus.Busy, bus.OutData);
        end
    endtask

    task automatic test_backpressure();
        logic [NUM*DW-1:0] pat;
        int                beats;
        int                cnt;
        pat        = mk_pat(8'h07, 8'h03);
        bus.OutRdy = 1'b0;
        do_load(pat);
        beats = 0;
        cnt   = 0;
        while (beats < NUM && cnt < 100) begin
            tests++;
            if ({bus.OutVld, bus.OutIdx, bus.OutLast, bus.OutData}
                !== {1'b1, IDXW'(beats), (beats == NUM - 1), wordf(8'h07, 8'h03, beats)}) begin
                fails++;
                $display("FAIL bp_cycle[%0d]: got vld=%b idx=%0d last=%b data=%h, required 1 %0d %b %h",
                         cnt, bus.OutVld, bus.OutIdx, bus.OutLast, bus.OutData,
                         beats, (beats == NUM - 1), wordf(8'h07, 8'h03, beats));
            end
            bus.OutRdy = ((cnt % 4) == 0) || ((cnt % 4) == 3);
            if (bus.OutRdy) beats++;
            cnt++;
            cyc();
        end
        tests++;
        if (beats != NUM) begin
            fails++;
            $display("FAIL bp_beat_count: got %0d required %0d", beats, NUM);
        end
        tests++;
        if (bus.OutVld !== 1'b0) begin
            fails++;
            $display("FAIL bp_end_idle: got OutVld=%b required 0", bus.OutVld);
        end
        bus.OutRdy = 1'b1;
    endtask

    task automatic test_load_during_drain();
        logic              exp_rdy;
        bus.OutRdy = 1'b1;
        do_load(mk_pat(8'h10, 8'h01));
        bus.LdVld  = 1'b1;
        bus.LdData = mk_pat(8'hF0, 8'h05);
        for (int i = 0; i < NUM; i++) begin
            if (i == NUM - 1) begin
                bus.LdVld = 1'b0;
                #1;
            end
`ifdef CPM_DRAIN_B2B_EN
            exp_rdy = (i == NUM - 1);
`else
            exp_rdy = 1'b0;
`endif
            tests++;
            if ({bus.OutVld, bus.OutIdx, bus.OutData, bus.LdRdy}
                !== {1'b1, IDXW'(i), wordf(8'h10, 8'h01, i), exp_rdy}) begin
                fails++;
                $display("FAIL ldd_beat[%0d]: got vld=%b idx=%0d data=%h ldrdy=%b, required 1 %0d %h %b",
                         i, bus.OutVld, bus.OutIdx, bus.OutData, bus.LdRdy,
                         i, wordf(8'h10, 8'h01, i), exp_rdy);
            end
            cyc();
        end
        tests++;
        if ({bus.OutVld, bus.LdRdy} !== 2'b01) begin
            fails++;
            $display("FAIL ldd_end_idle: got vld=%b ldrdy=%b, required 0 1", bus.OutVld, bus.LdRdy);
        end
    endtask

    task automatic test_clear(input bit use_rst);
        bit bank_zero;
        bus.OutRdy = 1'b1;
        do_load(mk_pat(8'h21, 8'h02));
        for (int i = 0; i < 5; i++) cyc();
        tests++;
        if ({bus.OutVld, bus.OutIdx, bus.OutData} !== {1'b1, 4'd5, wordf(8'h21, 8'h02, 5)}) begin
            fails++;
            $display("FAIL clr_pre[%0d]: got vld=%b idx=%0d data=%h, required 1 5 %h",
                     use_rst, bus.OutVld, bus.OutIdx, bus.OutData, wordf(8'h21, 8'h02, 5));
        end
        if (use_rst) Rst = 1'b1;
        else         Clear = 1'b1;
        bus.LdVld  = 1'b1;
        bus.LdData = mk_pat(8'h99, 8'h01);
        cyc();
        Rst       = 1'b0;
        Clear     = 1'b0;
        bus.LdVld = 1'b0;
        tests++;
        if ({bus.OutVld, bus.Busy, bus.LdRdy, bus.OutIdx, bus.OutData, bus.OutLast}
            !== {1'b0, 1'b0, 1'b1, 4'd0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL clr_outputs[%0d]: got vld=%b busy=%b ldrdy=%b idx=%0d data=%h last=%b, required 0 0 1 0 00 0",
                     use_rst, bus.OutVld, bus.Busy, bus.LdRdy, bus.OutIdx, bus.OutData, bus.OutLast);
        end
        tests++;
        if (dut.idx_q !== 4'd0) begin
            fails++;
            $display("FAIL clr_idx[%0d]: got %0d required 0", use_rst, dut.idx_q);
        end
        bank_zero = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            if (dut.u_bank.bank_q[i] !== 8'h00) bank_zero = 1'b0;
        end
        tests++;
        if (bank_zero !== 1'b1) begin
            fails++;
            $display("FAIL clr_bank[%0d]: got nonzero bank word, required all 00", use_rst);
        end
        cyc();
        tests++;
        if (bus.OutVld !== 1'b0) begin
            fails++;
            $display("FAIL clr_no_load[%0d]: got OutVld=%b required 0", use_rst, bus.OutVld);
        end
    endtask

    task automatic test_back_to_back();
        bus.OutRdy = 1'b1;
        do_load(mk_pat(8'h40, 8'h01));
        for (int i = 0; i < NUM - 1; i++) cyc();
        tests++;
        if ({bus.OutIdx, bus.OutLast, bus.OutData} !== {4'd15, 1'b1, 8'h4F}) begin
            fails++;
            $display("FAIL b2b_a_last: got idx=%0d last=%b data=%h, required 15 1 4f",
                     bus.OutIdx, bus.OutLast, bus.OutData);
        end
        bus.LdVld  = 1'b1;
        bus.LdData = mk_pat(8'h80, 8'h02);
        #1;
`ifdef CPM_DRAIN_B2B_EN
        tests++;
        if (bus.LdRdy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ldrdy_last: got %b required 1", bus.LdRdy);
        end
        cyc();
        bus.LdVld = 1'b0;
`else
        tests++;
        if (bus.LdRdy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ldrdy_last: got %b required 0", bus.LdRdy);
        end
        cyc();
        tests++;
        if ({bus.OutVld, bus.LdRdy} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_gap: got vld=%b ldrdy=%b, required 0 1", bus.OutVld, bus.LdRdy);
        end
        cyc();
        bus.LdVld = 1'b0;
`endif
        for (int i = 0; i < NUM; i++) begin
            tests++;
            if ({bus.OutVld, bus.OutIdx, bus.OutData} !== {1'b1, IDXW'(i), wordf(8'h80, 8'h02, i)}) begin
                fails++;
                $display("FAIL b2b_b_beat[%0d]: got vld=%b idx=%0d data=%h, required 1 %0d %h",
                         i, bus.OutVld, bus.OutIdx, bus.OutData, i, wordf(8'h80, 8'h02, i));
            end
            cyc();
        end
        tests++;
        if (bus.OutVld !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end_idle: got OutVld=%b required 0", bus.OutVld);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_load_during_drain();
        test_clear(1'b0);
        test_clear(1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
